// File: rtl/inst_rom_loader_if.sv
// Bus bundle between the boot loader / core and inst_rom_loader.
//   master : drives the fetch request (ce, addr) and the loader byte stream
//            (ld_start, ld_valid, ld_byte, ld_last); sees inst and status.
//   slave  : the ROM loader itself.
// MEM_AW must match the MEM_AW of the attached inst_rom_loader.
interface inst_rom_loader_if #(
    parameter int MEM_AW = 10
);
    logic              ce;        // fetch enable from core
    logic [31:0]       addr;      // fetch byte address
    logic [31:0]       inst;      // fetched word (0 = NOP when not allowed)
    logic              ld_start;  // one-cycle pulse: begin a load
    logic              ld_valid;  // loader byte valid
    logic [7:0]        ld_byte;   // loader byte
    logic              ld_last;   // final byte of image (with ld_valid)
    logic              ld_ready;  // byte accepted on ld_valid & ld_ready
    logic              ld_done;   // image loaded (level)
    logic              ld_ovf;    // image larger than memory (sticky)
    logic [MEM_AW:0]   ld_words;  // words written by current/last load
    logic              cpu_hold;  // keep core in reset

    modport master (
        output ce, addr, ld_start, ld_valid, ld_byte, ld_last,
        input  inst, ld_ready, ld_done, ld_ovf, ld_words, cpu_hold
    );

    modport slave (
        input  ce, addr, ld_start, ld_valid, ld_byte, ld_last,
        output inst, ld_ready, ld_done, ld_ovf, ld_words, cpu_hold
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial program loader.
// A load starts with ld_start; bytes arrive big-endian and are packed into
// 32-bit words written from address 0 upward. While a load is in progress
// the core is held in reset (cpu_hold=1) and fetches return 0; once the
// image ends (ld_last) the core is released and fetches read the memory
// combinationally.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : inst_rom_loader_if.slave (fetch port + loader stream + status)
module inst_rom_loader #(
    parameter int MEM_AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus
);
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {WAIT, COLLECT, WRITE, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      byte_cnt;
    // Doubles as ld_words: it saturates at DEPTH, so bit MEM_AW set means
    // the memory is full and no further write may happen.
    logic [MEM_AW:0] word_cnt;
    logic [31:0]     asm_word;
    logic            last_q;     // word being assembled ended with ld_last
    logic            ovf_q;
    logic [31:0]     mem [DEPTH];

    logic accept, do_write, ovf_set, room, hold, in_range;

    assign room = ~word_cnt[MEM_AW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT;
        else      state <= state_nxt;
    end

    // ld_start wins over everything, including a byte offered the same cycle
    // and a pending word write.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_write  = 1'b0;
        ovf_set   = 1'b0;
        if (bus.ld_start) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.ld_valid) begin
                        accept = 1'b1;
                        if (byte_cnt == 2'd3 || bus.ld_last) state_nxt = WRITE;
                    end
                end
                WRITE: begin
                    do_write  = room;
                    ovf_set   = ~room;
                    state_nxt = last_q ? DONE : COLLECT;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            asm_word <= 32'h0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.ld_start) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            asm_word <= 32'h0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                // Byte n lands in bits [31-8n -: 8]; the register is cleared
                // after each word so a short final word is zero-padded.
                asm_word[{~byte_cnt, 3'b000} +: 8] <= bus.ld_byte;
                byte_cnt <= byte_cnt + 2'd1;
                last_q   <= bus.ld_last;
            end
            if (state == WRITE) begin
                byte_cnt <= 2'd0;
                asm_word <= 32'h0;
                if (do_write) word_cnt <= word_cnt + (MEM_AW+1)'(1);
                if (ovf_set)  ovf_q    <= 1'b1;
            end
        end
    end

    // Memory has no reset; its contents survive both rst and new loads.
    always_ff @(posedge clk) begin
        if (do_write) mem[word_cnt[MEM_AW-1:0]] <= asm_word;
    end

    assign hold     = (state != DONE);
    assign in_range = (bus.addr[31:MEM_AW+2] == '0);

    // Reads only happen in DONE, writes only in WRITE, so they never collide.
    assign bus.inst     = (bus.ce && !hold && in_range) ? mem[bus.addr[MEM_AW+1:2]] : 32'h0;
    assign bus.ld_ready = (state == COLLECT);
    assign bus.ld_done  = (state == DONE);
    assign bus.cpu_hold = hold;
    assign bus.ld_ovf   = ovf_q;
    assign bus.ld_words = word_cnt;

    // Byte-lane bits of the fetch address carry no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];
endmodule

// File: tb/tb_inst_rom_loader.sv
// Two loaders (MEM_AW=10 and MEM_AW=2) share one stimulus stream; a
// behavioural model per instance predicts every status output and fetch.
module tb_inst_rom_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [7:0]  ld_byte = 8'h0;

    inst_rom_loader_if #(.MEM_AW(10)) b0 ();
    inst_rom_loader_if #(.MEM_AW(2))  b1 ();

    assign b0.ce = ce;  assign b0.addr = addr;  assign b0.ld_start = ld_start;
    assign b0.ld_valid = ld_valid;  assign b0.ld_byte = ld_byte;  assign b0.ld_last = ld_last;
    assign b1.ce = ce;  assign b1.addr = addr;  assign b1.ld_start = ld_start;
    assign b1.ld_valid = ld_valid;  assign b1.ld_byte = ld_byte;  assign b1.ld_last = ld_last;

    inst_rom_loader #(.MEM_AW(10)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    inst_rom_loader #(.MEM_AW(2))  dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, stalls = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting, 2 word write, 3 done
    int          m_phase[2], m_n[2], m_words[2];
    logic [31:0] m_cur[2];
    bit          m_last[2], m_ovf[2];
    logic [31:0] m_mem[2][1024];
    bit          m_wr[2][1024];

    function automatic int aw_of(input int d);
        return (d == 0) ? 10 : 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_phase[d] = 0; m_n[d] = 0; m_cur[d] = 0;
                m_last[d] = 0; m_words[d] = 0; m_ovf[d] = 0;
            end else if (ld_start) begin
                m_phase[d] = 1; m_n[d] = 0; m_cur[d] = 0;
                m_last[d] = 0; m_words[d] = 0; m_ovf[d] = 0;
            end else if (m_phase[d] == 1) begin
                if (ld_valid) begin
                    m_cur[d]  = m_cur[d] | (32'(ld_byte) << (24 - 8 * m_n[d]));
                    m_n[d]    = m_n[d] + 1;
                    m_last[d] = ld_last;
                    if (m_n[d] == 4 || ld_last) m_phase[d] = 2;
                end
            end else if (m_phase[d] == 2) begin
                if (m_words[d] < (1 << aw_of(d))) begin
                    m_mem[d][m_words[d]] = m_cur[d];
                    m_wr[d][m_words[d]]  = 1'b1;
                    m_words[d]           = m_words[d] + 1;
                end else begin
                    m_ovf[d] = 1'b1;
                end
                m_cur[d]   = 0;
                m_n[d]     = 0;
                m_phase[d] = m_last[d] ? 3 : 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    wire [1:0]  a_rdy  = {b1.ld_ready, b0.ld_ready};
    wire [1:0]  a_done = {b1.ld_done,  b0.ld_done};
    wire [1:0]  a_hold = {b1.cpu_hold, b0.cpu_hold};
    wire [1:0]  a_ovf  = {b1.ld_ovf,   b0.ld_ovf};
    wire [10:0] a_w0   = b0.ld_words;
    wire [2:0]  a_w1   = b1.ld_words;
    wire [31:0] a_i0   = b0.inst;
    wire [31:0] a_i1   = b1.inst;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int idx;
                idx = int'((addr >> 2) & ((32'd1 << aw_of(d)) - 1));
                chk($sformatf("ld_ready[%0d]", d), 32'(a_rdy[d]), 32'(m_phase[d] == 1));
                chk($sformatf("ld_done[%0d]", d),  32'(a_done[d]), 32'(m_phase[d] == 3));
                chk($sformatf("cpu_hold[%0d]", d), 32'(a_hold[d]), 32'(m_phase[d] != 3));
                chk($sformatf("ld_ovf[%0d]", d),   32'(a_ovf[d]), 32'(m_ovf[d]));
                chk($sformatf("ld_words[%0d]", d), (d == 0) ? 32'(a_w0) : 32'(a_w1), m_words[d]);
                if (!ce || m_phase[d] != 3 || (addr >> (aw_of(d) + 2)) != 0)
                    chk($sformatf("inst_nop[%0d]", d), (d == 0) ? a_i0 : a_i1, 32'h0);
                else if (m_wr[d][idx])
                    chk($sformatf("inst[%0d]", d), (d == 0) ? a_i0 : a_i1, m_mem[d][idx]);
            end
        end
    end

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start(input bit with_byte);
        ld_start = 1'b1;
        if (with_byte) begin
            ld_valid = 1'b1; ld_byte = 8'($urandom); ld_last = 1'($urandom);
        end
        step();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit last, input bit gaps);
        bit acc = 1'b0;
        int g = 0;
        while (!acc && g < 40) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0; ld_byte = 8'($urandom); ld_last = 1'($urandom);
            end else begin
                ld_valid = 1'b1; ld_byte = b; ld_last = last;
            end
            acc = ld_valid && b0.ld_ready;
            if (ld_valid && !acc) stalls++;
            step();
            g++;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        if (!acc) fail_timeout("send_byte");
    endtask

    task automatic send_img(input logic [7:0] q[$], input bit gaps);
        foreach (q[i]) send(q[i], i == q.size() - 1, gaps);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!b0.ld_done && g < 20) begin step(); g++; end
        if (!b0.ld_done) fail_timeout("wait_done");
    endtask

    // Random bytes offered while the loader is not collecting must vanish.
    task automatic noise(input int n);
        repeat (n) begin
            ld_valid = 1'($urandom); ld_byte = 8'($urandom); ld_last = 1'($urandom);
            ce = 1'($urandom); addr = $urandom_range(0, 63);
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic fetch_rand(input int n);
        repeat (n) begin
            ce = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0:       addr = $urandom();
                1:       addr = 32'h0010_0000;
                default: addr = $urandom_range(0, 31);
            endcase
            step();
        end
    endtask

    task automatic peek(input string name, input bit pce, input logic [31:0] a,
                        input int d, input logic [31:0] exp);
        ce = pce; addr = a;
        #1;
        chk(name, (d == 0) ? b0.inst : b1.inst, exp);
        step();
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] img[$];

    initial begin
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        ce = 1'b1; addr = 32'h0;
        repeat (2) step();
        chk("rst_ready", 32'(b0.ld_ready), 32'h0);
        chk("rst_hold",  32'(b0.cpu_hold), 32'h1);
        chk("rst_done",  32'(b0.ld_done),  32'h0);
        chk("rst_ovf",   32'(b0.ld_ovf),   32'h0);
        chk("rst_words", 32'(b0.ld_words), 32'h0);
        chk("rst_inst",  b0.inst,          32'h0);
        @(posedge clk); #3 rst = 1'b1;
        step();
        noise(4);

        // Two full words, back-to-back bytes: exactly one ready bubble.
        start(0);
        stalls = 0;
        img = '{8'h24, 8'h01, 8'h11, 8'h00, 8'h34, 8'h22, 8'h00, 8'h20};
        send_img(img, 0);
        chk("ready_bubble", stalls, 1);
        wait_done();
        chk("img1_words", 32'(b0.ld_words), 2);
        chk("img1_done",  32'(b0.ld_done),  1);
        chk("img1_hold",  32'(b0.cpu_hold), 0);
        peek("img1_a0", 1, 32'h0, 0, 32'h2401_1100);
        peek("img1_a4", 1, 32'h4, 0, 32'h3422_0020);
        peek("img1_a6", 1, 32'h6, 0, 32'h3422_0020);
        peek("img1_a6_small", 1, 32'h6, 1, 32'h3422_0020);
        noise(4);

        // Short final word is zero-padded in its low bytes.
        start(0);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_img(img, 1);
        wait_done();
        chk("img2_words", 32'(b0.ld_words), 2);
        peek("img2_w0", 1, 32'h0, 0, 32'hAABB_CCDD);
        peek("img2_w1", 1, 32'h4, 0, 32'hEE00_0000);

        // Restart mid-image (start wins over a same-cycle byte).
        start(0);
        for (int i = 0; i < 6; i++) send(8'($urandom), 0, 0);
        start(1);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_img(img, 0);
        wait_done();
        chk("img3_words", 32'(b0.ld_words), 1);
        peek("img3_w0", 1, 32'h0, 0, 32'h1122_3344);
        peek("img3_ce0", 0, 32'h0, 0, 32'h0);
        peek("img3_oor", 1, 32'h0010_0000, 0, 32'h0);

        // Five words into the four-word instance overflows.
        start(0);
        img = {};
        for (int i = 1; i <= 20; i++) img.push_back(8'(i));
        send_img(img, 1);
        wait_done();
        chk("ovf_small",   32'(b1.ld_ovf),   1);
        chk("words_small", 32'(b1.ld_words), 4);
        chk("ovf_big",     32'(b0.ld_ovf),   0);
        chk("words_big",   32'(b0.ld_words), 5);
        peek("small_w0", 1, 32'h0, 1, 32'h0102_0304);
        peek("small_w3", 1, 32'hC, 1, 32'h0D0E_0F10);
        peek("small_oor", 1, 32'h10, 1, 32'h0);

        // Randomized images, gaps and restarts.
        repeat (30) begin
            int len;
            start($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 7)); i++)
                    send(8'($urandom), 0, 1'($urandom));
                start($urandom_range(0, 1));
            end
            len = $urandom_range(1, 24);
            img = {};
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            send_img(img, 1'($urandom));
            wait_done();
            fetch_rand(8);
            noise(3);
        end

        // Asynchronous reset in the middle of collecting.
        start(0);
        send(8'h5A, 0, 0);
        send(8'hA5, 0, 0);
        ce = 1'b1; addr = 32'h0;
        #2 rst = 1'b0;
        #1;
        chk("async_ready", 32'(b0.ld_ready), 0);
        chk("async_hold",  32'(b0.cpu_hold), 1);
        chk("async_inst",  b0.inst,          0);
        chk("async_words", 32'(b1.ld_words), 0);
        step();
        noise(2);
        @(posedge clk); #3 rst = 1'b1;
        step();
        noise(5);
        chk("post_rst_ready", 32'(b0.ld_ready), 0);

        start(0);
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        send_img(img, 1);
        wait_done();
        peek("final_w0", 1, 32'h0, 0, 32'hDEAD_BEEF);
        peek("final_w1", 1, 32'h4, 1, 32'h0100_0000);
        fetch_rand(5);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
